// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Purpose : valid/ready bus between the memory-stage access unit (master)
//           and a memory or peripheral slave. There is one request channel
//           and one response channel, and at most one transaction is in
//           flight at a time.
// Signals : BusReqValid/BusReqReady  request handshake
//           BusAddr                  word-aligned address
//           BusWrite                 1 = write, 0 = read
//           BusWStrb                 byte enables (0000 on reads)
//           BusWData                 lane-replicated write data
//           BusRespValid             read data / write acknowledge valid
//           BusRData                 read word
interface mem_access_unit_if;
    logic        BusReqValid;
    logic        BusReqReady;
    logic [31:0] BusAddr;
    logic        BusWrite;
    logic [3:0]  BusWStrb;
    logic [31:0] BusWData;
    logic        BusRespValid;
    logic [31:0] BusRData;

    modport master (
        output BusReqValid, BusAddr, BusWrite, BusWStrb, BusWData,
        input  BusReqReady, BusRespValid, BusRData
    );

    modport slave (
        input  BusReqValid, BusAddr, BusWrite, BusWStrb, BusWData,
        output BusReqReady, BusRespValid, BusRData
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Purpose : memory-stage bus master. It turns the load/store sitting in M
//           into one bus transaction and stalls the pipeline until the
//           response arrives. It then hands the raw read word, the byte
//           offset and funct3 to W for alignment and sign extension.
//           Misaligned accesses are flagged and never reach the bus. An
//           access with no response is aborted after TIMEOUT_CYCLES.
// Ports   : CLK, RESETn                 clock, async active-low reset
//           MemReadM, MemWriteM         M-stage load / store
//           Funct3M, AddrM, WriteDataM  access type, address, store data
//           StallM, MisalignM, BusErrM  pipeline stall, misalign, timeout
//           bus                         master side of mem_access_unit_if
//           ReadDataW, ByteOffsetW,
//           Funct3W, LoadValidW         registered W-stage load results
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [31:0]       AddrM,
    input  logic [31:0]       WriteDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              BusErrM,
    mem_access_unit_if.master bus,
    output logic [31:0]       ReadDataW,
    output logic [1:0]        ByteOffsetW,
    output logic [2:0]        Funct3W,
    output logic              LoadValidW
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_count;
    logic        r_reqValid;
    logic [31:0] r_busAddr;
    logic        r_busWrite;
    logic [3:0]  r_busWStrb;
    logic [31:0] r_busWData;
    logic [31:0] r_readData;
    logic [1:0]  r_byteOffset;
    logic [2:0]  r_funct3;
    logic        r_loadValid;

    logic        w_access;
    logic        w_misalign;
    logic        w_req;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic        w_busy;
    logic        w_complete;
    logic        w_timeout;

    // Decode the access size from funct3[1:0] (bit 2 only selects signedness).
    // This block produces the alignment check, the byte lanes and the store
    // data replicated across all lanes.
    always_comb begin
        w_access   = MemReadM | MemWriteM;
        w_misalign = 1'b0;
        w_strb     = 4'b1111;
        w_wdata    = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << AddrM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_misalign = AddrM[0];
                w_strb     = 4'b0011 << AddrM[1:0];
                w_wdata    = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_misalign = (AddrM[1:0] != 2'b00);
            end
        endcase
        w_misalign = w_misalign & w_access;
        w_req      = w_access & ~w_misalign;
    end

    // Completion takes priority over timeout. A response that arrives in the
    // last allowed cycle still completes normally. An abort releases the
    // stall in that same cycle, so the stalled access is not reissued.
    always_comb begin
        w_busy     = (r_state == REQ) || (r_state == RESP);
        w_complete = (r_state == RESP) && bus.BusRespValid;
        w_timeout  = w_busy && (r_count == LAST_COUNT) && !w_complete;
        StallM     = RESETn & (((r_state == IDLE) & w_req) |
                               ((r_state == REQ)  & ~w_timeout) |
                               ((r_state == RESP) & ~bus.BusRespValid & ~w_timeout));
        MisalignM  = RESETn & w_misalign;
        BusErrM    = RESETn & w_timeout;
    end

    // Transaction FSM. Request fields are captured once in IDLE and held
    // until acceptance. The M-stage inputs stay frozen by the stall, so the
    // W offset and funct3 can be taken from them on the completing edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state      <= IDLE;
            r_count      <= 8'd0;
            r_reqValid   <= 1'b0;
            r_busAddr    <= 32'd0;
            r_busWrite   <= 1'b0;
            r_busWStrb   <= 4'd0;
            r_busWData   <= 32'd0;
            r_readData   <= 32'd0;
            r_byteOffset <= 2'd0;
            r_funct3     <= 3'd0;
            r_loadValid  <= 1'b0;
        end else begin
            r_loadValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state    <= REQ;
                        r_count    <= 8'd0;
                        r_reqValid <= 1'b1;
                        r_busAddr  <= {AddrM[31:2], 2'b00};
                        r_busWrite <= MemWriteM;
                        r_busWStrb <= MemWriteM ? w_strb : 4'b0000;
                        r_busWData <= w_wdata;
                    end
                end
                REQ: begin
                    if (w_timeout) begin
                        r_state    <= IDLE;
                        r_reqValid <= 1'b0;
                        r_readData <= 32'd0;
                    end else begin
                        r_count <= r_count + 8'd1;
                        if (bus.BusReqReady) begin
                            r_reqValid <= 1'b0;
                            r_state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.BusRespValid) begin
                        r_state <= IDLE;
                        if (!r_busWrite) begin
                            r_readData   <= bus.BusRData;
                            r_byteOffset <= AddrM[1:0];
                            r_funct3     <= Funct3M;
                            r_loadValid  <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state    <= IDLE;
                        r_readData <= 32'd0;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.BusReqValid = r_reqValid;
    assign bus.BusAddr     = r_busAddr;
    assign bus.BusWrite    = r_busWrite;
    assign bus.BusWStrb    = r_busWStrb;
    assign bus.BusWData    = r_busWData;
    assign ReadDataW       = r_readData;
    assign ByteOffsetW     = r_byteOffset;
    assign Funct3W         = r_funct3;
    assign LoadValidW      = r_loadValid;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Purpose : self-checking bench for mem_access_unit. It drives the M-stage
//           inputs and plays the bus slave with chosen ready/response delays.
//           A short timeout is used so the abort path is reachable quickly.
module tb_mem_access_unit;
    localparam int TIMEOUT = 8;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'd0;
    logic [31:0] AddrM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic        StallM, MisalignM, BusErrM, LoadValidW;
    logic [31:0] ReadDataW;
    logic [1:0]  ByteOffsetW;
    logic [2:0]  Funct3W;

    mem_access_unit_if busIf ();

    mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .AddrM(AddrM), .WriteDataM(WriteDataM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .bus(busIf.master),
        .ReadDataW(ReadDataW), .ByteOffsetW(ByteOffsetW),
        .Funct3W(Funct3W), .LoadValidW(LoadValidW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          readyDelay;
        int          respDelay;
        logic        expMis;
        logic [3:0]  expStrb;
        logic [31:0] expWData;
    } vec_t;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference view of the W registers: the last completed load.
    logic [31:0] expReadW = 32'd0;
    logic [1:0]  expOffW  = 2'd0;
    logic [2:0]  expF3W   = 3'd0;

    vec_t vecs [12];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkW();
        checkOutput("ReadDataW", ReadDataW, expReadW);
        checkOutput("ByteOffsetW", {30'd0, ByteOffsetW}, {30'd0, expOffW});
        checkOutput("Funct3W", {29'd0, Funct3W}, {29'd0, expF3W});
    endtask

    // Reference model, written from the access rules rather than the RTL:
    // access size is 1 << funct3[1:0] bytes, and an access is misaligned
    // when the address is not a multiple of the size. Lanes are a
    // size-wide mask shifted by the byte offset. Store data is the low
    // bytes multiplied out across the word.
    function automatic vec_t makeVec(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata, input int rdy, input int rsp);
        vec_t v;
        int size;
        int mask;
        size = 1 << f3[1:0];
        mask = ((1 << size) - 1) << (addr % 4);
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.readyDelay = rdy; v.respDelay = rsp;
        v.expMis = (rd | wr) && ((addr % size) != 0);
        v.expStrb = wr ? mask[3:0] : 4'b0000;
        if (size == 1)      v.expWData = 32'(wdata[7:0]) * 32'h01010101;
        else if (size == 2) v.expWData = 32'(wdata[15:0]) * 32'h00010001;
        else                v.expWData = wdata;
        return v;
    endfunction

    // Run one M-stage access: issue, play the slave with the requested
    // delays, and check request fields every cycle and W after completion.
    task automatic applyStimulus(input vec_t v);
        MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3;
        AddrM = v.addr; WriteDataM = v.wdata;
        busIf.BusReqReady = 1'b0; busIf.BusRespValid = 1'b0;
        #1;
        checkOutput("MisalignM", {31'd0, MisalignM}, {31'd0, v.expMis});
        if (!(v.rd | v.wr) || v.expMis) begin
            checkOutput("StallM no request", {31'd0, StallM}, 32'd0);
            tick();
            checkOutput("BusReqValid no request", {31'd0, busIf.BusReqValid}, 32'd0);
            checkOutput("LoadValidW no request", {31'd0, LoadValidW}, 32'd0);
            checkW();
            return;
        end
        checkOutput("StallM issue", {31'd0, StallM}, 32'd1);
        tick();
        for (int k = 0; k <= v.readyDelay; k++) begin
            busIf.BusReqReady = (k == v.readyDelay);
            #1;
            checkOutput("BusReqValid", {31'd0, busIf.BusReqValid}, 32'd1);
            checkOutput("BusAddr", busIf.BusAddr, {v.addr[31:2], 2'b00});
            checkOutput("BusWrite", {31'd0, busIf.BusWrite}, {31'd0, v.wr});
            checkOutput("BusWStrb", {28'd0, busIf.BusWStrb}, {28'd0, v.expStrb});
            if (v.wr) checkOutput("BusWData", busIf.BusWData, v.expWData);
            checkOutput("StallM req", {31'd0, StallM}, 32'd1);
            checkOutput("BusErrM req", {31'd0, BusErrM}, 32'd0);
            if (k == 0) checkOutput("LoadValidW req", {31'd0, LoadValidW}, 32'd0);
            tick();
        end
        busIf.BusReqReady = 1'b0;
        for (int k = 0; k <= v.respDelay; k++) begin
            busIf.BusRespValid = (k == v.respDelay);
            busIf.BusRData = (k == v.respDelay) ? v.rdata : $urandom;
            #1;
            checkOutput("BusReqValid resp", {31'd0, busIf.BusReqValid}, 32'd0);
            checkOutput("StallM resp", {31'd0, StallM}, {31'd0, (k != v.respDelay)});
            tick();
        end
        busIf.BusRespValid = 1'b0;
        if (v.rd) begin
            expReadW = v.rdata; expOffW = v.addr[1:0]; expF3W = v.f3;
        end
        checkOutput("LoadValidW done", {31'd0, LoadValidW}, {31'd0, v.rd});
        checkW();
    endtask

    // Access with a slave that accepts but never answers.
    task automatic timeoutCase();
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; AddrM = 32'h0000A000;
        busIf.BusReqReady = 1'b0; busIf.BusRespValid = 1'b0;
        tick();
        busIf.BusReqReady = 1'b1;
        #1;
        checkOutput("BusErrM first", {31'd0, BusErrM}, 32'd0);
        tick();
        busIf.BusReqReady = 1'b0;
        for (int c = 1; c < TIMEOUT; c++) begin
            #1;
            checkOutput("BusErrM timeout", {31'd0, BusErrM}, {31'd0, (c == TIMEOUT - 1)});
            checkOutput("StallM timeout", {31'd0, StallM}, {31'd0, (c != TIMEOUT - 1)});
            tick();
        end
        MemReadM = 1'b0;
        expReadW = 32'd0;
        #1;
        checkOutput("BusErrM after", {31'd0, BusErrM}, 32'd0);
        checkOutput("LoadValidW after timeout", {31'd0, LoadValidW}, 32'd0);
        checkOutput("BusReqValid after timeout", {31'd0, busIf.BusReqValid}, 32'd0);
        checkOutput("StallM after timeout", {31'd0, StallM}, 32'd0);
        checkW();
        busIf.BusRespValid = 1'b1; busIf.BusRData = 32'h55AA55AA;
        tick();
        busIf.BusRespValid = 1'b0;
        checkOutput("LoadValidW late resp", {31'd0, LoadValidW}, 32'd0);
        checkW();
    endtask

    // Pull reset low in REQ (phase 0) or RESP (phase 1), while the load
    // is still held in M.
    task automatic resetMidAccess(input int phase);
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; AddrM = 32'h00009000;
        busIf.BusReqReady = 1'b0; busIf.BusRespValid = 1'b0;
        tick();
        if (phase == 1) begin
            busIf.BusReqReady = 1'b1;
            tick();
            busIf.BusReqReady = 1'b0;
        end
        checkOutput("BusReqValid pre-reset", {31'd0, busIf.BusReqValid}, {31'd0, (phase == 0)});
        checkOutput("StallM pre-reset", {31'd0, StallM}, 32'd1);
        RESETn = 1'b0;
        #1;
        checkOutput("BusReqValid in reset", {31'd0, busIf.BusReqValid}, 32'd0);
        checkOutput("StallM in reset", {31'd0, StallM}, 32'd0);
        checkOutput("LoadValidW in reset", {31'd0, LoadValidW}, 32'd0);
        busIf.BusRespValid = 1'b1; busIf.BusRData = 32'h13579BDF;
        tick();
        expReadW = 32'd0; expOffW = 2'd0; expF3W = 3'd0;
        checkW();
        busIf.BusRespValid = 1'b0; MemReadM = 1'b0;
        RESETn = 1'b1;
        tick();
        checkOutput("LoadValidW post-reset", {31'd0, LoadValidW}, 32'd0);
        checkOutput("StallM post-reset", {31'd0, StallM}, 32'd0);
    endtask

    // Main sequence: reset state, directed table, timeout, resets, random.
    initial begin
        busIf.BusReqReady = 1'b0; busIf.BusRespValid = 1'b0; busIf.BusRData = 32'd0;
        tick();
        tick();
        checkOutput("reset BusReqValid", {31'd0, busIf.BusReqValid}, 32'd0);
        checkOutput("reset StallM", {31'd0, StallM}, 32'd0);
        checkOutput("reset BusErrM", {31'd0, BusErrM}, 32'd0);
        checkOutput("reset LoadValidW", {31'd0, LoadValidW}, 32'd0);
        checkOutput("reset BusWStrb", {28'd0, busIf.BusWStrb}, 32'd0);
        checkW();
        RESETn = 1'b1;
        tick();

        //           rd    wr    f3      addr          wdata         rdata       rdy rsp mis  strb     wdata
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00001004, 32'h00000000, 32'hDEADBEEF, 0, 0, 1'b0, 4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h00002003, 32'h000000A5, 32'h0,        0, 0, 1'b0, 4'b1000, 32'hA5A5A5A5};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h00002002, 32'h1234BEEF, 32'h0,        0, 0, 1'b0, 4'b1100, 32'hBEEFBEEF};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h00002001, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h00003002, 32'h0,        32'h11223344, 5, 0, 1'b0, 4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h00004000, 32'hCAFEF00D, 32'h0,        1, 1, 1'b0, 4'b1111, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h00004002, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h00005001, 32'hFFFF0000, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b101, 32'h00006002, 32'h0,        32'h89ABCDEF, 5, 1, 1'b0, 4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h00007001, 32'h0000003C, 32'h0,        2, 0, 1'b0, 4'b0010, 32'h3C3C3C3C};
        vecs[10] = '{1'b0, 1'b0, 3'b010, 32'h00000001, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h00008003, 32'h0,        32'h12345678, 1, 3, 1'b0, 4'b0000, 32'h0};

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        timeoutCase();
        resetMidAccess(0);
        resetMidAccess(1);
        applyStimulus(vecs[0]);

        for (int i = 0; i < 80; i++) begin
            int kind;
            logic [2:0] f3;
            kind = $urandom_range(0, 2);
            if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'b101;
            end
            applyStimulus(makeVec(kind == 1, kind == 2, f3, $urandom, $urandom, $urandom,
                                  $urandom_range(0, 3), $urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage bus master that turns a pipelined load/store in M into a single valid/ready bus transaction.
- Generates byte strobes and replicated write data for SB/SH/SW.
- Stalls the pipeline until the response arrives, then registers the raw read word, byte offset and funct3 into W for the downstream load alignment/sign-extension logic.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: cycles from entering REQ without a response before the access is aborted; width of the timeout counter is 8 bits (must be ≤255).

Ports:
- CLK  in  1  system clock, rising edge
- RESETn  in  1  asynchronous active-low reset
- MemReadM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- Funct3M  in  3  RISC-V funct3 of M instruction
- AddrM  in  32  effective address
- WriteDataM  in  32  store source register value
- StallM  out  1  hold F/D/E/M pipeline registers (combinational)
- MisalignM  out  1  combinational misaligned-access flag
- BusErrM  out  1  one-cycle pulse, access aborted by timeout
- BusReqValid  out  1  request valid (registered)
- BusReqReady  in  1  slave accepts request
- BusAddr  out  32  word-aligned address ({AddrM[31:2],2'b00})
- BusWrite  out  1  1=write, 0=read
- BusWStrb  out  4  byte enables (0000 for reads)
- BusWData  out  32  write data
- BusRespValid  in  1  read data / write ack valid
- BusRData  in  32  read word
- ReadDataW  out  32  registered raw read word to W
- ByteOffsetW  out  2  registered AddrM[1:0]
- Funct3W  out  3  registered Funct3M
- LoadValidW  out  1  registered: W holds a completed load

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0.
  - RESETn low mid-transaction: immediate return to IDLE, BusReqValid drops, no W update. The bus slave is reset together with this unit.
- Misaligned:
  - LH/LHU/SH with AddrM[0]=1.
  - LW/SW with AddrM[1:0]≠00.
  - MisalignM=1 only when MemReadM|MemWriteM; no bus request, StallM=0, LoadValidW=0 next cycle.
- Request: req = (MemReadM|MemWriteM) & !MisalignM.
- Strobes/data:
  - SB: 0001<<AddrM[1:0], {4{WriteDataM[7:0]}}.
  - SH: 0011<<AddrM[1:0], {2{WriteDataM[15:0]}}.
  - SW: 1111, WriteDataM.
- FSM IDLE, REQ, RESP:
  - IDLE: if req, capture BusAddr/BusWrite/BusWStrb/BusWData, set BusReqValid=1, counter=0, go REQ.
  - REQ: BusReqValid and all request fields held stable until BusReqReady=1, then BusReqValid=0 and go RESP. BusRespValid is ignored in REQ; responses come ≥1 cycle after acceptance.
  - RESP: on BusRespValid, go IDLE.
    - Same edge for a load: ReadDataW=BusRData, ByteOffsetW, Funct3W, LoadValidW=1.
    - Same edge for a store: LoadValidW=0.
- StallM = (IDLE & req) | REQ | (RESP & !BusRespValid). StallM is 0 in the completing cycle, so the pipeline advances on the same edge that loads W.
- Non-stalled cycle with no completing load: LoadValidW=0 at next edge, other W fields hold.
- Minimum latency: 3 M-stage cycles (2 stall cycles) with ready and response each asserted at first opportunity.
- Timeout: counter increments every cycle in REQ/RESP. When counter reaches TIMEOUT_CYCLES-1 without completion:
  - BusReqValid=0, go IDLE, BusErrM=1 for one cycle, StallM=0 in that cycle.
  - LoadValidW=0, ReadDataW=0.
- Late or unexpected BusRespValid in IDLE: ignored.
- Back-to-back accesses: next request always passes through IDLE; there is one outstanding transaction max.

Test Plan:
- LW AddrM=0x1004, ready in REQ first cycle, resp next cycle, BusRData=0xDEADBEEF -> StallM high 2 cycles, BusAddr=0x1004, BusWStrb=0000, ReadDataW=0xDEADBEEF, ByteOffsetW=00, LoadValidW=1 for one cycle.
- SB AddrM=0x2003 WriteDataM=0x000000A5 -> BusWStrb=1000, BusWData=0xA5A5A5A5, BusWrite=1, LoadValidW stays 0.
- SH AddrM=0x2002 WriteDataM=0x1234BEEF -> BusWStrb=1100, BusWData=0xBEEFBEEF. LH AddrM=0x2001 -> MisalignM=1, no BusReqValid, StallM=0.
- BusReqReady held low 5 cycles during LBU AddrM=0x3002 -> BusReqValid, BusAddr=0x3000 stable all 5 cycles, StallM stays 1, then completes with ByteOffsetW=10, Funct3W=100.
- TIMEOUT_CYCLES=8, ready given, no response -> after 8 cycles in REQ/RESP: BusErrM single pulse, StallM=0, LoadValidW=0, state IDLE.
- RESETn pulled low in RESP -> BusReqValid, StallM, LoadValidW all 0 asynchronously. After release, a fresh LW completes normally.
